// File: rtl/dispatch_iq_skid_if.sv
// Dispatch-to-issue-queue bundle bus.
// Carries the dispatch-side bundle handshake, the per-queue ready vector,
// the queue write lanes, and the stage occupancy.
// master = dispatch/queue environment, slave = the skid stage.
interface dispatch_iq_skid_if #(
  parameter int NUM_CH = 3,
  parameter int LANES  = 2,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 2
);
  localparam int WL    = NUM_CH * LANES;
  localparam int BW    = WL * DATA_W;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [WL-1:0]     in_wen;
  logic [BW-1:0]     in_data;
  logic [NUM_CH-1:0] ch_ready;
  logic [WL-1:0]     out_wen;
  logic [BW-1:0]     out_data;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output in_valid, in_wen, in_data, ch_ready,
    input  in_ready, out_wen, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_wen, in_data, ch_ready,
    output in_ready, out_wen, out_data, occupancy
  );
endinterface

// File: rtl/dispatch_iq_skid.sv
// Dispatch -> reservation-station skid stage.
// Holds up to DEPTH dispatch bundles (NUM_CH x LANES write lanes each) and
// releases the oldest one atomically when the queues it targets are ready.
// All-zero bundles are swallowed at the input so they never cost a cycle
// at the output. in_ready depends only on the occupancy register, so the
// dispatch side never sees same-cycle queue backpressure.
module dispatch_iq_skid #(
  parameter int NUM_CH    = 3,
  parameter int LANES     = 2,
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 2,
  parameter bit ALL_READY = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  dispatch_iq_skid_if.slave  bus
);
  localparam int WL    = NUM_CH * LANES;
  localparam int BW    = WL * DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Bundle storage: one write-enable vector and one payload per entry.
  logic [WL-1:0] wen_mem  [DEPTH];
  logic [BW-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;

  logic              not_empty;
  logic              space;
  logic              push;
  logic              pop;
  logic              go;
  logic              cond;
  logic              any_wen;
  logic [NUM_CH-1:0] ch_ok;
  logic [WL-1:0]     head_wen;
  logic [BW-1:0]     head_data;

  // ---------------------------------------------------------------------
  // Status and handshake
  // ---------------------------------------------------------------------
  assign not_empty = (occ_reg != '0);
  assign space     = (occ_reg < OCC_FULL);
  assign any_wen   = |bus.in_wen;

  // Empty bundles are consumed but never stored.
  assign push = bus.in_valid && space && !flush && any_wen;

  assign head_wen  = wen_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];

  // Per-channel readiness: a channel not written by the head bundle
  // never blocks it.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_ok
      assign ch_ok[gi] = !(|head_wen[gi*LANES +: LANES]) || bus.ch_ready[gi];
    end
  endgenerate

  assign cond = ALL_READY ? (&bus.ch_ready) : (&ch_ok);
  assign go   = not_empty && !flush && cond;
  assign pop  = go;

  // ---------------------------------------------------------------------
  // Output lanes: write enables gated by issue, payload gated by occupancy
  // so an empty stage drives a clean zero bus.
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WL; gi++) begin : g_lane
      assign bus.out_wen[gi] = head_wen[gi] & go;
      assign bus.out_data[gi*DATA_W +: DATA_W] =
        not_empty ? head_data[gi*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  assign bus.in_ready  = space;
  assign bus.occupancy = occ_reg;

  // Occupancy next state: +push -pop, simultaneous push/pop is a no-op.
  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + OCC_ONE;
      2'b01:   occ_next = occ_reg - OCC_ONE;
      default: occ_next = occ_reg;
    endcase
  end

  // Pointer and occupancy registers; flush empties the stage in one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      occ_reg <= occ_next;
    end
  end

  // One storage slot per entry, written when the tail points at it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Entry gi captures the incoming bundle on a push to its slot.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wen_mem[gi]  <= '0;
          data_mem[gi] <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          wen_mem[gi]  <= bus.in_wen;
          data_mem[gi] <= bus.in_data;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_dispatch_iq_skid.sv
// Scoreboard bench for dispatch_iq_skid.
// dut_a: ALL_READY=1, dut_b: ALL_READY=0, both DEPTH=2, 3 channels x 2 lanes.
// Stimulus pushes the bundles expected to leave each stage into a queue;
// a negedge monitor per DUT pops and compares whenever out_wen is non-zero.
module tb_dispatch_iq_skid;
  localparam int NUM_CH = 3;
  localparam int LANES  = 2;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 2;
  localparam int WL     = NUM_CH * LANES;
  localparam int BW     = WL * DATA_W;

  typedef struct packed {
    logic [WL-1:0] wen;
    logic [BW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_a = 1'b0;
  logic flush_b = 1'b0;

  always #5 clk = ~clk;

  dispatch_iq_skid_if #(.NUM_CH(NUM_CH), .LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) a_if ();
  dispatch_iq_skid_if #(.NUM_CH(NUM_CH), .LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH)) b_if ();

  dispatch_iq_skid #(
    .NUM_CH(NUM_CH), .LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .ALL_READY(1'b1)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_a),
    .bus   (a_if.slave)
  );

  dispatch_iq_skid #(
    .NUM_CH(NUM_CH), .LANES(LANES), .DATA_W(DATA_W), .DEPTH(DEPTH), .ALL_READY(1'b0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush_b),
    .bus   (b_if.slave)
  );

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t e_a;
  exp_t e_b;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   flow_chk = 1'b0;

  function automatic logic [BW-1:0] mk(input logic [DATA_W-1:0] v);
    return {WL{v}};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic exp_push(input bit sel_b, input logic [WL-1:0] w, input logic [DATA_W-1:0] v);
    exp_t e;
    e.wen  = w;
    e.data = mk(v);
    if (sel_b) exp_b.push_back(e);
    else       exp_a.push_back(e);
  endtask

  // Present a bundle, wait (bounded) for in_ready, then let one edge take it.
  task automatic send(input bit sel_b, input logic [WL-1:0] w, input logic [DATA_W-1:0] v);
    int n = 0;
    if (sel_b) begin
      b_if.in_valid = 1'b1; b_if.in_wen = w; b_if.in_data = mk(v);
    end else begin
      a_if.in_valid = 1'b1; a_if.in_wen = w; a_if.in_data = mk(v);
    end
    forever begin
      @(negedge clk);
      if (sel_b ? b_if.in_ready : a_if.in_ready) break;
      n++;
      if (n > 40) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (sel_b) begin
      b_if.in_valid = 1'b0; b_if.in_wen = '0; b_if.in_data = '0;
    end else begin
      a_if.in_valid = 1'b0; a_if.in_wen = '0; a_if.in_data = '0;
    end
  endtask

  // Wait (bounded) until the stage is empty and every expected bundle left.
  task automatic drain(input bit sel_b);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (sel_b) done = (b_if.occupancy == 0) && (exp_b.size() == 0);
      else       done = (a_if.occupancy == 0) && (exp_a.size() == 0);
    end
    chk(sel_b ? "drain_b" : "drain_a", BW'(done), BW'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for dut_a: every issued bundle must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && a_if.out_wen != '0) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_a: got wen=%b, expected no issue", a_if.out_wen);
      end else begin
        e_a = exp_a.pop_front();
        $display("txn a: wen=%b data=%0h", a_if.out_wen, a_if.out_data[DATA_W-1:0]);
        chk("issue_a_wen", BW'(a_if.out_wen), BW'(e_a.wen));
        chk("issue_a_data", a_if.out_data, e_a.data);
      end
    end
    if (flow_chk) begin
      chk("flow_in_ready", BW'(a_if.in_ready), BW'(1));
      chk("flow_occ_le1", BW'(a_if.occupancy <= 1), BW'(1));
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin
    if (rst_n && b_if.out_wen != '0) begin
      if (exp_b.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_b: got wen=%b, expected no issue", b_if.out_wen);
      end else begin
        e_b = exp_b.pop_front();
        $display("txn b: wen=%b data=%0h", b_if.out_wen, b_if.out_data[DATA_W-1:0]);
        chk("issue_b_wen", BW'(b_if.out_wen), BW'(e_b.wen));
        chk("issue_b_data", b_if.out_data, e_b.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    a_if.in_valid = 1'b0; a_if.in_wen = '0; a_if.in_data = '0; a_if.ch_ready = '0;
    b_if.in_valid = 1'b0; b_if.in_wen = '0; b_if.in_data = '0; b_if.ch_ready = '0;

    // Reset state
    #12;
    chk("rst_in_ready_a", BW'(a_if.in_ready), BW'(1));
    chk("rst_occ_a", BW'(a_if.occupancy), BW'(0));
    chk("rst_out_wen_a", BW'(a_if.out_wen), BW'(0));
    chk("rst_out_data_a", a_if.out_data, BW'(0));
    chk("rst_in_ready_b", BW'(b_if.in_ready), BW'(1));
    chk("rst_occ_b", BW'(b_if.occupancy), BW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic flow: four back-to-back bundles, all queues ready
    a_if.ch_ready = 3'b111;
    for (int v = 1; v <= 4; v++) exp_push(1'b0, 6'b000011, 64'(v));
    flow_chk = 1'b1;
    for (int v = 1; v <= 4; v++) send(1'b0, 6'b000011, 64'(v));
    @(negedge clk);
    step();
    flow_chk = 1'b0;
    drain(1'b0);

    // Stall and fill: LSU queue not ready blocks everything in ALL_READY mode
    a_if.ch_ready = 3'b011;
    exp_push(1'b0, 6'b010100, 64'd5);
    exp_push(1'b0, 6'b100001, 64'd6);
    exp_push(1'b0, 6'b000110, 64'd7);
    send(1'b0, 6'b010100, 64'd5);
    send(1'b0, 6'b100001, 64'd6);
    a_if.in_valid = 1'b1; a_if.in_wen = 6'b000110; a_if.in_data = mk(64'd7);
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", BW'(a_if.in_ready), BW'(0));
      chk("stall_occ", BW'(a_if.occupancy), BW'(2));
      chk("stall_out_wen", BW'(a_if.out_wen), BW'(0));
    end
    step();
    a_if.ch_ready = 3'b111;
    send(1'b0, 6'b000110, 64'd7);
    drain(1'b0);

    // Empty bundle is swallowed; next real bundle keeps 1-cycle latency
    send(1'b0, 6'b000000, 64'd99);
    @(negedge clk);
    chk("empty_occ", BW'(a_if.occupancy), BW'(0));
    chk("empty_out_wen", BW'(a_if.out_wen), BW'(0));
    step();
    exp_push(1'b0, 6'b001100, 64'd8);
    send(1'b0, 6'b001100, 64'd8);
    @(negedge clk);
    chk("latency_out_wen", BW'(a_if.out_wen), BW'(6'b001100));
    step();
    drain(1'b0);

    // Flush with a full stage and a valid input in the same cycle
    a_if.ch_ready = 3'b000;
    send(1'b0, 6'b111111, 64'd31);
    send(1'b0, 6'b111111, 64'd32);
    @(negedge clk);
    chk("flush_fill_occ", BW'(a_if.occupancy), BW'(2));
    step();
    flush_a = 1'b1;
    a_if.ch_ready = 3'b111;
    a_if.in_valid = 1'b1; a_if.in_wen = 6'b000011; a_if.in_data = mk(64'd33);
    @(negedge clk);
    chk("flush_cycle_wen", BW'(a_if.out_wen), BW'(0));
    step();
    flush_a = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_wen = '0; a_if.in_data = '0;
    @(negedge clk);
    chk("flush_occ", BW'(a_if.occupancy), BW'(0));
    chk("flush_in_ready", BW'(a_if.in_ready), BW'(1));
    chk("flush_out_wen", BW'(a_if.out_wen), BW'(0));
    step();
    repeat (3) step();

    // Per-channel readiness (dut_b, ALL_READY=0)
    b_if.ch_ready = 3'b001;
    exp_push(1'b1, 6'b000001, 64'd21);
    send(1'b1, 6'b000001, 64'd21);
    @(negedge clk);
    chk("m0_alu_issue", BW'(b_if.out_wen), BW'(6'b000001));
    step();
    exp_push(1'b1, 6'b000100, 64'd22);
    send(1'b1, 6'b000100, 64'd22);
    repeat (3) begin
      @(negedge clk);
      chk("m0_mdu_wait_wen", BW'(b_if.out_wen), BW'(0));
      chk("m0_mdu_wait_occ", BW'(b_if.occupancy), BW'(1));
    end
    step();
    b_if.ch_ready = 3'b011;
    @(negedge clk);
    chk("m0_mdu_issue", BW'(b_if.out_wen), BW'(6'b000100));
    step();
    drain(1'b1);

    // Asynchronous reset in the middle of a stall
    a_if.ch_ready = 3'b000;
    send(1'b0, 6'b000011, 64'd41);
    send(1'b0, 6'b000011, 64'd42);
    @(negedge clk);
    chk("areset_pre_occ", BW'(a_if.occupancy), BW'(2));
    @(posedge clk);
    #2;
    a_if.ch_ready = 3'b111;
    rst_n = 1'b0;
    #1;
    chk("areset_out_wen", BW'(a_if.out_wen), BW'(0));
    chk("areset_out_data", a_if.out_data, BW'(0));
    chk("areset_occ", BW'(a_if.occupancy), BW'(0));
    chk("areset_in_ready", BW'(a_if.in_ready), BW'(1));
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step();
    repeat (4) begin
      @(negedge clk);
      chk("post_reset_out_wen", BW'(a_if.out_wen), BW'(0));
      chk("post_reset_occ", BW'(a_if.occupancy), BW'(0));
    end
    step();

    chk("scoreboard_a_empty", BW'(exp_a.size()), BW'(0));
    chk("scoreboard_b_empty", BW'(exp_b.size()), BW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dispatch_iq_skid.md
# dispatch_iq_skid

Parametrised, flow-controlled pipeline stage between the dispatch stage and the NUM_CH reservation-station queues (ALU/MDU/LSU, ...). Each cycle it accepts one dispatch bundle of NUM_CH×LANES write lanes into a DEPTH-entry bundle FIFO. It releases the oldest bundle atomically once the required queues report ready. Unlike a single hold register, it decouples dispatch from same-cycle queue backpressure, skips empty bundles, and supports a per-channel readiness mode.

## Interface
- NUM_CH, 3: number of downstream queues (channel c = ALU, MDU, LSU, ...).
- LANES, 2: write lanes per channel. Unused lanes are tied low by the parent.
- DATA_W, 64: payload width per lane (queue meta packed flat).
- DEPTH, 2: bundle FIFO entries. Power of 2, at least 2.
- ALL_READY, 1: 1 = issue only when every ch_ready is high. 0 = issue when ch_ready is high for every channel with a set wen bit in the head bundle.
- clk  in  1  clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush, active high.
- in_valid  in  1  dispatch bundle present.
- in_ready  out  1  stage can accept a bundle.
- in_wen  in  NUM_CH*LANES  lane write enables. Bit c*LANES+l is channel c, lane l.
- in_data  in  NUM_CH*LANES*DATA_W  lane payloads, same lane ordering.
- ch_ready  in  NUM_CH  per-queue ready, i.e. the queue can take LANES writes this cycle.
- out_wen  out  NUM_CH*LANES  queue write enables.
- out_data  out  NUM_CH*LANES*DATA_W  queue payloads.
- occupancy  out  $clog2(DEPTH+1)  bundles held.

## Operation
- **Accept.** A bundle is accepted when in_valid && in_ready && !flush.
  - If the bundle's in_wen is all zero, it is accepted and discarded. It is not enqueued.
  - Otherwise it is written at the tail.
- **Ready.** in_ready = (occupancy < DEPTH). It has no combinational dependence on ch_ready or in_valid.
- **Issue condition.** go = (occupancy != 0) && !flush && cond, where:
  - ALL_READY=1: cond = &ch_ready.
  - ALL_READY=0: cond = for all c, !(|head_wen[c]) || ch_ready[c].
- **Outputs.**
  - out_wen = head_wen masked by go.
  - out_data = head payload when occupancy != 0, else 0.
- **Pop.** The head is popped on the same edge that go is high. A bundle is never split across cycles.
- **Pointers and count.** Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The count is updated by +push −pop.
  - Push and pop on the same edge leaves occupancy unchanged.
- **Flush.**
  - On the edge: all entries are discarded, both pointers are set to 0, and occupancy is set to 0.
  - In the flush cycle itself: out_wen is forced to 0 and in_valid is ignored.
- **Reset (rst_n low).** Asynchronous.
  - Pointers, occupancy and storage are cleared to 0.
  - out_wen = 0, out_data = 0, in_ready = 1, occupancy = 0.
  - Release is clean mid-operation: after reset there is no stale issue.

## Timing
- Latency: a bundle accepted at edge k into an empty stage drives out_wen during cycle k+1. It pops at edge k+1 if go is high.
- Throughput: 1 bundle/cycle sustained with all ch_ready high, for DEPTH ≥ 2. in_ready stays at 1.
- Backpressure: with ch_ready held low, occupancy rises to DEPTH and then in_ready = 0.
  - When full, a pop frees a slot on the edge; in_ready returns to 1 in the next cycle.
- Critical path: ch_ready → out_wen is one AND/OR level. in_ready is a register-derived compare only.
- Ordering: bundles leave strictly in acceptance order. Head-of-line blocking is intended.

## Test plan
- **Basic flow.** Reset, then 4 back-to-back bundles with in_wen=6'b000011 and data 1..4, all ch_ready=1 → out_wen=000011 in cycles 1..4, data 1,2,3,4 in order, in_ready constantly 1, occupancy ≤ 1.
- **Stall and fill.** DEPTH=2, ALL_READY=1, ch_ready=3'b011, send 3 bundles → occupancy 2 and in_ready=0 after 2 accepts; out_wen=0 throughout. Raise ch_ready=111 → bundles issue on consecutive cycles, in order, with the third accepted after the first pop.
- **Mode 0 readiness.** ALL_READY=0, head in_wen=6'b000001 (ALU only), ch_ready=3'b001 → issues next cycle. A head with MDU lane set waits until ch_ready[1]=1.
- **Empty bundle.** in_valid=1 with in_wen=0 → occupancy stays 0 and out_wen stays 0. The next real bundle is issued with 1-cycle latency.
- **Flush.** Fill to 2, then pulse flush with in_valid=1 in the same cycle → out_wen=0 that cycle, occupancy=0 next cycle, the flush-cycle input is dropped, in_ready=1.
- **Async reset.** Assert rst_n low mid-stall (occupancy 2) between clock edges → out_wen, out_data and occupancy are 0 immediately and in_ready=1. After release, no bundle is emitted.
